// File: rtl/inst_decode_ctl.sv
// inst_decode_ctl: instruction register, path-type decode, end-of-instruction and halt control
module inst_decode_ctl (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [11:0] BUS,
  input  logic        STB_FETCH,
  input  logic        STB_AUTO1,
  input  logic        STB_AUTO2,
  input  logic        STB_IND,
  input  logic        STB_1,
  input  logic        STB_2,
  input  logic        STB_3,
  input  logic        STB_4,
  input  logic        STB_5,
  input  logic        STB_6,
  output logic [11:0] IR,
  output logic [1:0]  SEQTYPE,
  output logic        DONE,
  output logic        HALT_REQ,
  output logic        SEQERR,
  output logic [15:0] ICNT
);
  logic [11:0] ir_q, ir_d;
  logic        halt_q, halt_d;
  logic        err_q, err_d;
  logic [15:0] icnt_q, icnt_d;
  logic [8:0]  w_hi;
  logic        w_ind, w_auto, ir_ind, ir_auto;
  logic [5:0]  stb;
  logic [2:0]  n;
  logic        done, over, err_set;
  assign stb  = {STB_6, STB_5, STB_4, STB_3, STB_2, STB_1};
  assign w_hi = STB_FETCH ? BUS[11:3] : ir_q[11:3];
  assign w_ind   = (w_hi[8:6] < 3'd6) & w_hi[5];
  assign w_auto  = w_ind & ~w_hi[4] & (w_hi[3:0] == 4'b0001);
  assign ir_ind  = (ir_q[11:9] < 3'd6) & ir_q[8];
  assign ir_auto = ir_ind & ~ir_q[7] & (ir_q[6:3] == 4'b0001);
  // execute length of the instruction currently held in IR
  always_comb begin
    case (ir_q[11:9])
      3'd2, 3'd7: n = 3'd4;
      3'd4, 3'd6: n = 3'd3;
      3'd5:       n = 3'd1;
      default:    n = 3'd2;
    endcase
  end
  assign done = ~RESET & stb[n - 3'd1];
  assign over = |(stb >> n);
  assign err_set = over
                 | ((STB_AUTO1 | STB_AUTO2) & ~ir_auto)
                 | (STB_IND & ~ir_ind)
                 | (STB_FETCH & (STB_AUTO1 | STB_AUTO2 | STB_IND | (|stb)));
  // next-state for IR, halt pulse, sticky error and retire counter
  always_comb begin
    ir_d   = STB_FETCH ? BUS : ir_q;
    halt_d = done & (ir_q[11:9] == 3'd7) & ir_q[8] & ~ir_q[0] & ir_q[1];
    err_d  = err_q | err_set;
    icnt_d = icnt_q + 16'(done);
  end
  // state registers; reset overrides every load and set
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ir_q   <= '0;
      halt_q <= 1'b0;
      err_q  <= 1'b0;
      icnt_q <= '0;
    end else begin
      ir_q   <= ir_d;
      halt_q <= halt_d;
      err_q  <= err_d;
      icnt_q <= icnt_d;
    end
  end
  assign IR       = ir_q;
  assign SEQTYPE  = {w_auto, w_ind};
  assign DONE     = done;
  assign HALT_REQ = halt_q;
  assign SEQERR   = err_q;
  assign ICNT     = icnt_q;
endmodule

// File: tb/tb_inst_decode_ctl.sv
// tb_inst_decode_ctl: directed checks of fetch, path decode, execute length, halt, error and reset
module tb_inst_decode_ctl;
  logic        CLK = 1'b0;
  logic        RESET;
  logic [11:0] BUS;
  logic        STB_FETCH, STB_AUTO1, STB_AUTO2, STB_IND;
  logic        STB_1, STB_2, STB_3, STB_4, STB_5, STB_6;
  logic [11:0] IR;
  logic [1:0]  SEQTYPE;
  logic        DONE, HALT_REQ, SEQERR;
  logic [15:0] ICNT;
  int checks = 0;
  int errors = 0;

  inst_decode_ctl dut (
    .CLK(CLK), .RESET(RESET), .BUS(BUS),
    .STB_FETCH(STB_FETCH), .STB_AUTO1(STB_AUTO1), .STB_AUTO2(STB_AUTO2), .STB_IND(STB_IND),
    .STB_1(STB_1), .STB_2(STB_2), .STB_3(STB_3), .STB_4(STB_4), .STB_5(STB_5), .STB_6(STB_6),
    .IR(IR), .SEQTYPE(SEQTYPE), .DONE(DONE), .HALT_REQ(HALT_REQ), .SEQERR(SEQERR), .ICNT(ICNT)
  );

  always #5 CLK = ~CLK;

  task automatic clr();
    STB_FETCH = 0; STB_AUTO1 = 0; STB_AUTO2 = 0; STB_IND = 0;
    STB_1 = 0; STB_2 = 0; STB_3 = 0; STB_4 = 0; STB_5 = 0; STB_6 = 0;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
    clr();
    #1;
  endtask

  task automatic do_reset();
    RESET = 1; tick(); RESET = 0; #1;
  endtask

  task automatic fetch(input logic [11:0] w);
    BUS = w; STB_FETCH = 1; #1;
  endtask

  task automatic test_reset();
    clr(); BUS = 12'o7777; RESET = 1;
    tick(); tick();
    RESET = 0; #1;
    checks++; if (IR !== 12'o0000) begin errors++; $display("FAIL reset_ir got %o exp 0000", IR); end
    checks++; if (SEQTYPE !== 2'b00) begin errors++; $display("FAIL reset_seqtype got %b exp 00", SEQTYPE); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", DONE); end
    checks++; if (HALT_REQ !== 1'b0) begin errors++; $display("FAIL reset_halt got %b exp 0", HALT_REQ); end
    checks++; if (SEQERR !== 1'b0) begin errors++; $display("FAIL reset_seqerr got %b exp 0", SEQERR); end
    checks++; if (ICNT !== 16'd0) begin errors++; $display("FAIL reset_icnt got %0d exp 0", ICNT); end
  endtask

  task automatic test_tad();
    fetch(12'o1050);
    checks++; if (SEQTYPE !== 2'b00) begin errors++; $display("FAIL tad_seqtype got %b exp 00", SEQTYPE); end
    tick();
    checks++; if (IR !== 12'o1050) begin errors++; $display("FAIL tad_ir got %o exp 1050", IR); end
    STB_1 = 1; #1;
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL tad_done1 got %b exp 0", DONE); end
    tick(); STB_2 = 1; #1;
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL tad_done2 got %b exp 1", DONE); end
    tick();
    checks++; if (ICNT !== 16'd1) begin errors++; $display("FAIL tad_icnt got %0d exp 1", ICNT); end
    checks++; if (SEQERR !== 1'b0) begin errors++; $display("FAIL tad_seqerr got %b exp 0", SEQERR); end
  endtask

  task automatic test_seqtype();
    fetch(12'o1410);
    checks++; if (SEQTYPE !== 2'b11) begin errors++; $display("FAIL st_auto got %b exp 11", SEQTYPE); end
    tick();
    checks++; if (SEQTYPE !== 2'b11) begin errors++; $display("FAIL st_auto_ir got %b exp 11", SEQTYPE); end
    fetch(12'o1450);
    checks++; if (SEQTYPE !== 2'b01) begin errors++; $display("FAIL st_ind got %b exp 01", SEQTYPE); end
    tick();
    fetch(12'o7410);
    checks++; if (SEQTYPE !== 2'b00) begin errors++; $display("FAIL st_opr got %b exp 00", SEQTYPE); end
    tick();
    fetch(12'o6017);
    checks++; if (SEQTYPE !== 2'b00) begin errors++; $display("FAIL st_iot got %b exp 00", SEQTYPE); end
    tick();
    fetch(12'o0417);
    checks++; if (SEQTYPE !== 2'b11) begin errors++; $display("FAIL st_auto17 got %b exp 11", SEQTYPE); end
    tick();
    fetch(12'o0420);
    checks++; if (SEQTYPE !== 2'b01) begin errors++; $display("FAIL st_ind20 got %b exp 01", SEQTYPE); end
    tick();
  endtask

  task automatic test_length();
    do_reset();
    fetch(12'o2000); tick();
    STB_1 = 1; tick();
    STB_2 = 1; #1;
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL isz_done2 got %b exp 0", DONE); end
    tick(); STB_3 = 1; #1;
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL isz_done3 got %b exp 0", DONE); end
    tick(); STB_4 = 1; #1;
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL isz_done4 got %b exp 1", DONE); end
    tick();
    fetch(12'o5000); tick();
    STB_1 = 1; #1;
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL jmp_done1 got %b exp 1", DONE); end
    tick();
    fetch(12'o4000); tick();
    STB_2 = 1; #1;
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL jms_done2 got %b exp 0", DONE); end
    tick(); STB_3 = 1; #1;
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL jms_done3 got %b exp 1", DONE); end
    tick();
    checks++; if (ICNT !== 16'd3) begin errors++; $display("FAIL len_icnt got %0d exp 3", ICNT); end
    checks++; if (SEQERR !== 1'b0) begin errors++; $display("FAIL len_seqerr got %b exp 0", SEQERR); end
  endtask

  task automatic test_halt();
    fetch(12'o7402); tick();
    STB_1 = 1; tick(); STB_2 = 1; tick(); STB_3 = 1; #1;
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL hlt_done3 got %b exp 0", DONE); end
    tick(); STB_4 = 1; #1;
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL hlt_done4 got %b exp 1", DONE); end
    checks++; if (HALT_REQ !== 1'b0) begin errors++; $display("FAIL hlt_early got %b exp 0", HALT_REQ); end
    tick();
    checks++; if (HALT_REQ !== 1'b1) begin errors++; $display("FAIL hlt_pulse got %b exp 1", HALT_REQ); end
    tick();
    checks++; if (HALT_REQ !== 1'b0) begin errors++; $display("FAIL hlt_clear got %b exp 0", HALT_REQ); end
    fetch(12'o7400); tick();
    STB_1 = 1; tick(); STB_2 = 1; tick(); STB_3 = 1; tick(); STB_4 = 1; tick();
    checks++; if (HALT_REQ !== 1'b0) begin errors++; $display("FAIL nohlt got %b exp 0", HALT_REQ); end
    fetch(12'o7403); tick();
    STB_1 = 1; tick(); STB_2 = 1; tick(); STB_3 = 1; tick(); STB_4 = 1; tick();
    checks++; if (HALT_REQ !== 1'b0) begin errors++; $display("FAIL hlt_grp3 got %b exp 0", HALT_REQ); end
    checks++; if (SEQERR !== 1'b0) begin errors++; $display("FAIL hlt_seqerr got %b exp 0", SEQERR); end
  endtask

  task automatic test_seqerr();
    do_reset();
    fetch(12'o5000); tick();
    STB_2 = 1; tick();
    checks++; if (SEQERR !== 1'b1) begin errors++; $display("FAIL err_over got %b exp 1", SEQERR); end
    fetch(12'o1050); tick();
    STB_1 = 1; tick(); STB_2 = 1; #1;
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL err_done got %b exp 1", DONE); end
    tick();
    checks++; if (SEQERR !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", SEQERR); end
    checks++; if (ICNT !== 16'd1) begin errors++; $display("FAIL err_icnt got %0d exp 1", ICNT); end
    do_reset();
    checks++; if (SEQERR !== 1'b0) begin errors++; $display("FAIL err_reset got %b exp 0", SEQERR); end
    fetch(12'o1050); tick();
    STB_IND = 1; tick();
    checks++; if (SEQERR !== 1'b1) begin errors++; $display("FAIL err_ind got %b exp 1", SEQERR); end
    do_reset();
    fetch(12'o1450); tick();
    STB_IND = 1; tick();
    checks++; if (SEQERR !== 1'b0) begin errors++; $display("FAIL err_ind_ok got %b exp 0", SEQERR); end
    STB_AUTO1 = 1; tick();
    checks++; if (SEQERR !== 1'b1) begin errors++; $display("FAIL err_auto got %b exp 1", SEQERR); end
    do_reset();
    fetch(12'o1410); tick();
    STB_AUTO1 = 1; tick(); STB_AUTO2 = 1; tick(); STB_IND = 1; tick();
    checks++; if (SEQERR !== 1'b0) begin errors++; $display("FAIL err_auto_ok got %b exp 0", SEQERR); end
    fetch(12'o2000); STB_1 = 1; tick();
    checks++; if (SEQERR !== 1'b1) begin errors++; $display("FAIL err_fetch got %b exp 1", SEQERR); end
    checks++; if (IR !== 12'o2000) begin errors++; $display("FAIL err_fetch_ir got %o exp 2000", IR); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      fetch(12'o5000); tick();
      STB_1 = 1; tick();
    end
    STB_IND = 1; tick();
    fetch(12'o2000); tick();
    checks++; if (ICNT !== 16'd5 || SEQERR !== 1'b1) begin errors++; $display("FAIL mid_pre got icnt %0d err %b exp 5 1", ICNT, SEQERR); end
    STB_1 = 1; tick(); STB_2 = 1; tick();
    STB_3 = 1; RESET = 1; #1;
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL mid_done3 got %b exp 0", DONE); end
    tick(); RESET = 0; #1;
    checks++; if (IR !== 12'o0 || ICNT !== 16'd0 || SEQERR !== 1'b0 || HALT_REQ !== 1'b0)
      begin errors++; $display("FAIL mid_state got ir %o icnt %0d err %b halt %b exp 0 0 0 0", IR, ICNT, SEQERR, HALT_REQ); end
    fetch(12'o5000); tick();
    STB_1 = 1; RESET = 1; #1;
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL mid_done_last got %b exp 0", DONE); end
    tick(); RESET = 0; #1;
    checks++; if (ICNT !== 16'd0) begin errors++; $display("FAIL mid_icnt got %0d exp 0", ICNT); end
  endtask

  task automatic test_wrap();
    do_reset();
    fetch(12'o5000); tick();
    for (int i = 0; i < 65535; i++) begin
      STB_1 = 1; @(posedge CLK); #1;
    end
    clr(); #1;
    checks++; if (ICNT !== 16'hFFFF) begin errors++; $display("FAIL wrap_max got %h exp ffff", ICNT); end
    STB_1 = 1; tick();
    checks++; if (ICNT !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h exp 0000", ICNT); end
    checks++; if (SEQERR !== 1'b0) begin errors++; $display("FAIL wrap_seqerr got %b exp 0", SEQERR); end
  endtask

  initial begin
    test_reset();
    test_tad();
    test_seqtype();
    test_length();
    test_halt();
    test_seqerr();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
